// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the destination-domain round-robin arbiter.
package cdc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Modulo-n increment with an explicit wrap, valid for any n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_first_set.sv
// Combinational circular priority pick: first set request at or after start_i.
module rr_first_set
  import cdc_arb_pkg::*;
#(
  parameter int unsigned NumIn    = 4,
  localparam int unsigned IdxWidth = idx_width(NumIn)
) (
  input  logic [NumIn-1:0]    req_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  logic [IdxWidth:0]   cand;
  logic [IdxWidth-1:0] cand_idx;

  always_comb begin
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      // One extra bit keeps start+k from overflowing before the wrap.
      cand = {1'b0, start_i} + (IdxWidth + 1)'(k);
      if (cand >= (IdxWidth + 1)'(NumIn)) cand = cand - (IdxWidth + 1)'(NumIn);
      cand_idx = cand[IdxWidth-1:0];
      if (!any_o && req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cdc_dst_rr_arbiter.sv
// Round-robin scheduler sharing one valid/ready sink between NumIn CDC FIFO
// read ports; each grant lasts at most MaxBurst handshakes.
module cdc_dst_rr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter type         T        = logic,
  parameter int unsigned NumIn    = 4,
  parameter int unsigned MaxBurst = 4,
  localparam int unsigned IdxWidth = idx_width(NumIn),
  localparam int unsigned CntWidth = idx_width(MaxBurst)
) (
  input  logic                dst_clk_i,
  input  logic                dst_rst_ni,
  input  logic                clr_i,
  input  T [NumIn-1:0]        in_data_i,
  input  logic [NumIn-1:0]    in_valid_i,
  output logic [NumIn-1:0]    in_ready_o,
  output T                    out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [IdxWidth-1:0] out_idx_o
);

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] gnt_q, gnt_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [IdxWidth-1:0] pick_idx;
  logic                pick_any;
  logic                granted;
  logic                handshake;
  logic                burst_done;
  logic [IdxWidth-1:0] gnt_inc;

  rr_first_set #(
    .NumIn (NumIn)
  ) u_pick (
    .req_i   (in_valid_i),
    .start_i (rr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign granted    = (state_q == GRANT);
  assign handshake  = out_valid_o && out_ready_i;
  assign burst_done = (cnt_q == CntWidth'(MaxBurst - 1));
  assign gnt_inc    = IdxWidth'(rr_next(32'(gnt_q), NumIn));

  // Pass-through datapath; everything is gated by state_q, so an async reset
  // drops valid and ready immediately.
  always_comb begin
    out_data_o  = in_data_i[gnt_q];
    out_idx_o   = gnt_q;
    out_valid_o = granted && in_valid_i[gnt_q];
    in_ready_o  = '0;
    if (granted) in_ready_o[gnt_q] = out_ready_i;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = IDLE;
      gnt_d   = '0;
      rr_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_d = GRANT;
            gnt_d   = pick_idx;
            cnt_d   = '0;
          end
        end
        GRANT: begin
          // Release only on a handshake or with valid already low, so an
          // offered word is never withdrawn.
          if (!in_valid_i[gnt_q]) begin
            state_d = IDLE;
            rr_d    = gnt_inc;
          end else if (handshake) begin
            cnt_d = cnt_q + 1'b1;
            if (burst_done) begin
              state_d = IDLE;
              rr_d    = gnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
